// File: rtl/sha256_block_sequencer_if.sv
// rtl/sha256_block_sequencer_if.sv - host message/digest and round-unit signal bundle
interface sha256_block_sequencer_if #(
  parameter int DELAY_W = 7
);
  logic               init;
  logic               msg_valid;
  logic [31:0]        msg_data;
  logic               msg_ready;
  logic               busy;
  logic               digest_valid;
  logic [255:0]       digest;
  logic               f_run;
  logic [DELAY_W-1:0] f_delay0;
  logic [255:0]       f_state;
  logic [31:0]        f_w;
  logic [31:0]        f_k;
  logic [255:0]       f_out;

  modport master (
    output init, msg_valid, msg_data, f_out,
    input  msg_ready, busy, digest_valid, digest, f_run, f_delay0, f_state, f_w, f_k
  );

  modport slave (
    input  init, msg_valid, msg_data, f_out,
    output msg_ready, busy, digest_valid, digest, f_run, f_delay0, f_state, f_w, f_k
  );
endinterface

// File: rtl/sha256_block_sequencer.sv
// rtl/sha256_block_sequencer.sv - SHA-256 block loader, message scheduler and chaining-value update
// The round arithmetic lives in an external round unit; this block feeds it W[r]/K[r] and folds its result into H.
module sha256_block_sequencer #(
  parameter int DELAY_W = 7
) (
  input logic                   clk,
  input logic                   rst,
  sha256_block_sequencer_if.slave bus
);
  typedef enum logic [2:0] {IDLE, LOAD, FIRE, ROUND, CAPTURE} state_t;

  localparam logic [0:7][31:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] sigma0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sigma1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  state_t           state;
  logic [31:0]      window [16];
  logic [3:0]       word_cnt;
  logic [5:0]       rnd;
  logic [0:7][31:0] h;
  logic             run_q;
  logic             dv_q;
  logic             ready_q;
  logic             busy_q;

  logic        xfer;
  logic        do_shift;
  logic [31:0] next_w;
  logic [31:0] shift_in;

  assign xfer     = bus.msg_valid && ready_q;
  assign next_w   = sigma1(window[14]) + window[9] + sigma0(window[1]) + window[0];
  // The same window shifter serves both message loading and schedule expansion.
  assign do_shift = (state == ROUND) || (((state == IDLE) || (state == LOAD)) && xfer);
  assign shift_in = (state == ROUND) ? next_w : bus.msg_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      for (int i = 0; i < 16; i++) window[i] <= '0;
      word_cnt <= '0;
      rnd      <= '0;
      h        <= IV;
      run_q    <= 1'b0;
      dv_q     <= 1'b0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      run_q <= 1'b0;
      dv_q  <= 1'b0;
      if (do_shift) begin
        for (int i = 0; i < 15; i++) window[i] <= window[i+1];
        window[15] <= shift_in;
      end
      case (state)
        IDLE: begin
          if (bus.init) h <= IV;
          if (xfer) begin
            word_cnt <= word_cnt + 4'd1;
            state    <= LOAD;
          end
        end
        LOAD: begin
          if (xfer) begin
            word_cnt <= word_cnt + 4'd1;
            if (word_cnt == 4'd15) begin
              state   <= FIRE;
              run_q   <= 1'b1;
              ready_q <= 1'b0;
              busy_q  <= 1'b1;
            end
          end
        end
        FIRE: begin
          rnd   <= '0;
          state <= ROUND;
        end
        ROUND: begin
          rnd <= rnd + 6'd1;
          if (rnd == 6'd63) state <= CAPTURE;
        end
        CAPTURE: begin
          for (int i = 0; i < 8; i++) h[i] <= h[i] + bus.f_out[255-32*i -: 32];
          state   <= IDLE;
          dv_q    <= 1'b1;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.msg_ready    = ready_q;
  assign bus.busy         = busy_q;
  assign bus.digest_valid = dv_q;
  assign bus.digest       = h;
  assign bus.f_state      = h;
  assign bus.f_run        = run_q;
  assign bus.f_delay0     = {DELAY_W{1'b0}};
  assign bus.f_w          = (state == ROUND) ? window[0] : 32'h0;
  assign bus.f_k          = (state == ROUND) ? K[rnd] : 32'h0;
endmodule

// File: doc/sha256_block_sequencer.md
SHA256_BLOCK_SEQUENCER -- requirements
Module: sha256_block_sequencer

Interface
REQ-001 SHALL have parameter DELAY_W, default 7, width of the f_delay0 output to the round unit.
REQ-002 SHALL have port clk  input  1  clock, rising-edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port init  input  1  one-cycle pulse that reloads the SHA-256 IV into H; honoured only in IDLE.
REQ-005 SHALL have port msg_valid  input  1  message word valid.
REQ-006 SHALL have port msg_data  input  32  message word, big-endian word order M0..M15.
REQ-007 SHALL have port msg_ready  output  1  sequencer accepts msg_data this cycle.
REQ-008 SHALL have port busy  output  1  high in FIRE, ROUND and CAPTURE.
REQ-009 SHALL have port digest_valid  output  1  one-cycle pulse when digest holds the updated chaining value.
REQ-010 SHALL have port digest  output  256  H0..H7, H0 in bits 255:224.
REQ-011 SHALL have port f_run  output  1  start pulse to the round unit.
REQ-012 SHALL have port f_delay0  output  DELAY_W  round-unit delay; constant 0.
REQ-013 SHALL have port f_state  output  256  initial a..h to the round unit (a in 255:224); equals digest.
REQ-014 SHALL have port f_w  output  32  schedule word W[r] to the round unit.
REQ-015 SHALL have port f_k  output  32  round constant K[r] to the round unit.
REQ-016 SHALL have port f_out  input  256  round-unit a..h after the final round (a in 255:224).

Function
REQ-017 SHALL implement states IDLE, LOAD, FIRE, ROUND, CAPTURE.
REQ-018 SHALL drive msg_ready=1 in IDLE and LOAD, 0 otherwise; a word transfers on msg_valid&&msg_ready.
REQ-019 SHALL shift each accepted word into a 16x32 window at slot 15, moving all slots down by one; a 4-bit word counter increments per transfer.
REQ-020 SHALL go IDLE->LOAD on the first accepted word, and LOAD->FIRE on the transfer of the 16th word; msg_valid gaps only stall the counter.
REQ-021 SHALL assert f_run for exactly the one FIRE cycle, then enter ROUND with round counter r=0.
REQ-022 SHALL, in ROUND cycle r (0..63), drive f_w=window[0] and f_k=K[r] from a 64-entry FIPS 180-4 constant ROM, then increment r.
REQ-023 SHALL, each ROUND cycle, shift the window down and write slot 15 = sigma1(w[14]) + w[9] + sigma0(w[1]) + w[0] mod 2^32; sigma0 = ROTR7^ROTR18^SHR3, sigma1 = ROTR17^ROTR19^SHR10.
REQ-024 SHALL go ROUND->CAPTURE after r=63, and in CAPTURE set each Hi <= Hi + f_out word i, mod 2^32 per word.
REQ-025 SHALL go CAPTURE->IDLE and assert digest_valid in that first IDLE cycle only, with digest already updated.
REQ-026 SHALL therefore show digest_valid exactly 67 cycles after the cycle in which the 16th word transfers.
REQ-027 SHALL hold f_w, f_k at 0 outside ROUND and keep f_state = H at all times.
REQ-028 SHALL chain blocks: a following block uses the updated H unless init pulses in IDLE first.
REQ-029 SHALL ignore init outside IDLE; if init and a word transfer coincide in IDLE, SHALL load the IV and accept the word.
REQ-030 SHALL ignore msg_valid while busy; a hashed message with no padding errors is not the sequencer's concern, since padding is done by the host.

Reset
REQ-031 SHALL on rst force: state IDLE, H = IV (6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19), window, counters, f_run, digest_valid all 0, and msg_ready = 1.
REQ-032 SHALL on rst during any state abandon the block and discard partial window contents with no digest_valid pulse.

Verification
REQ-033 "abc" padded block (61626380, 0 x14, 00000018) after reset -> digest_valid once; digest ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
REQ-034 Empty-string block (80000000, 0 x15) after init -> digest e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
REQ-035 Two-block 448-bit "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" -> digest_valid after each block; final digest 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
REQ-036 "abc" with random msg_valid gaps -> same digest as REQ-033; f_run high exactly 1 cycle; digest_valid exactly 67 cycles after the 16th transfer.
REQ-037 rst asserted at ROUND r=30, then "abc" block -> no digest_valid for the aborted block; digest equals the REQ-033 value.
REQ-038 init and msg_valid pulsed while busy -> msg_ready 0, H and chaining unaffected, next digest correct.
